reset_seq: RTL
==============

// Module: reset_seq
// PURPOSE
//   Parametrised reset synchronizer and sequencer for one clock domain.
//   Synchronizes board reset BRSTn, stretches every reset to a minimum length
//   and releases NUM_OUT reset outputs in staged order, lowest index first.
//   Also accepts a software reset request and records the cause of the last
//   reset. Sits at the top level and drives the datapath, control and
//   coefficient-memory resets.
// PARAMETERS
//   SYNC_STAGES  2   BRSTn synchronizer depth; must be >= 2
//   NUM_OUT      4   number of staged reset outputs; must be >= 1
//   MIN_ASSERT   16  cycles that req must stay low before arst_n[0] releases; >= 1
//   STAGE_GAP    8   cycles between release of arst_n[k-1] and arst_n[k]; >= 1
// PORTS
//   clk        in   1        system clock
//   PORn       in   1        power-on reset; asynchronous, active-low
//   BRSTn      in   1        board reset, active-low, asynchronous to clk
//   sw_rst_req in   1        synchronous software reset request (pulse or level)
//   cause_clr  in   1        synchronous clear of rst_cause
//   arst_n     out  NUM_OUT  staged resets, active-low; bit 0 releases first
//   rst_done   out  1        high once all arst_n bits are released
//   rst_cause  out  2        last reset cause: 00 none, 01 POR, 10 BRST, 11 SW
// BEHAVIOUR
// - PORn low (async): sync chain = 0, state = HOLD, cnt = 0, arst_n = 0,
//   rst_done = 0, rst_cause = 01.
// - Reset assertion is asynchronous only via PORn. Everything else is synchronous.
// - BRSTn passes through a SYNC_STAGES flop chain that resets to 0; brst_s is
//   the last stage.
// - req = ~brst_s | sw_rst_req.
// - cnt width = $clog2(max(MIN_ASSERT, STAGE_GAP) + 1).
// - HOLD (arst_n all 0):
//     - req = 1: cnt <= 0.
//     - req = 0 and cnt == MIN_ASSERT-1: arst_n[0] <= 1, cnt <= 0, go to REL
//       (go to DONE and set rst_done <= 1 if NUM_OUT == 1).
//     - otherwise: cnt <= cnt + 1.
// - REL (stage index k = 1..NUM_OUT-1):
//     - cnt counts to STAGE_GAP-1, then arst_n[k] <= 1, cnt <= 0, k++.
//     - The edge that releases arst_n[NUM_OUT-1] also sets rst_done <= 1 and
//       moves to DONE.
// - DONE: all outputs high and stable.
// - req = 1 in REL or DONE: on the next edge, all arst_n <= 0, rst_done <= 0,
//   cnt <= 0, go to HOLD. A reset request always preempts a sequence in progress.
// - Released bits stay high in order: arst_n is always of the form 0..01..1
//   (thermometer), never with a gap.
// - rst_cause:
//     - Set on the edge that forces a non-HOLD state to HOLD: 10 if ~brst_s,
//       else 11. BRST has priority over SW when both occur together.
//     - A request while already in HOLD does not change rst_cause.
//     - cause_clr sets rst_cause <= 00 unless a new cause is recorded on the
//       same edge; the new cause wins.
// - Latency from PORn rising (BRSTn high, req otherwise low), edges numbered
//   from 1:
//     - arst_n[0] rises at edge SYNC_STAGES + MIN_ASSERT.
//     - arst_n[k] rises STAGE_GAP*k edges later.
//     - rst_done rises with arst_n[NUM_OUT-1].
// - sw_rst_req sampled high at edge E, req low afterwards: arst_n[0] rises at
//   edge E + MIN_ASSERT.
// - A BRSTn low glitch shorter than one cycle may be missed. A glitch that is
//   captured always yields a full MIN_ASSERT stretch.
// TESTING (defaults unless stated)
// 1. PORn low 5 cycles, then high with BRSTn = 1 -> arst_n 0000 until edge 18;
//    0001 @18, 0011 @26, 0111 @34, 1111 and rst_done = 1 @42; rst_cause = 01.
// 2. In DONE, 1-cycle sw_rst_req sampled @E -> arst_n 0000 and rst_cause 11
//    after E; arst_n[0] high @E+16; rst_done @E+40.
// 3. BRSTn low 3 cycles during REL (arst_n = 0011) -> all low 2-3 edges
//    later, rst_cause 10; full sequence restarts 16 edges after brst_s
//    returns high.
// 4. sw_rst_req and BRSTn low together in DONE -> rst_cause 10; cause_clr
//    in the same cycle -> still 10; cause_clr alone later -> 00.
// 5. PORn pulsed low mid-REL, asynchronous to clk -> arst_n 0 and rst_done 0
//    immediately, without waiting for an edge; rst_cause 01; sequence per
//    test 1.
// 6. NUM_OUT=1, MIN_ASSERT=1, SYNC_STAGES=3 -> arst_n[0] and rst_done rise
//    together @edge 4 after PORn release.

Source files
------------

// File: rtl/reset_seq.sv
// reset_seq: BRSTn synchronizer plus staged, stretched release of NUM_OUT active-low resets.
// Records the cause of the most recent reset (POR, board reset or software request).
module reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic               clk,
  input  logic               PORn,
  input  logic               BRSTn,
  input  logic               sw_rst_req,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] arst_n,
  output logic               rst_done,
  output logic [1:0]         rst_cause
);
  localparam int MAXC = MIN_ASSERT > STAGE_GAP ? MIN_ASSERT : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {HOLD, REL, DONE} state_t;
  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_OUT-1:0]   arst_n_q;
  logic                 done_q;
  logic [1:0]           cause_q;
  logic                 brst_s;
  logic                 req;
  logic [NUM_OUT-1:0]   arst_n_d;
  assign brst_s   = sync_q[SYNC_STAGES-1];
  assign req      = ~brst_s | sw_rst_req;
  // next thermometer value: one more bit released from the bottom
  assign arst_n_d = (arst_n_q << 1) | NUM_OUT'(1);
  assign arst_n    = arst_n_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;
  always_ff @(posedge clk or negedge PORn) begin
    if (!PORn) begin
      sync_q   <= '0;
      state_q  <= HOLD;
      cnt_q    <= '0;
      arst_n_q <= '0;
      done_q   <= 1'b0;
      cause_q  <= 2'b01;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], BRSTn};
      cause_q <= (req && state_q != HOLD) ? (~brst_s ? 2'b10 : 2'b11) : cause_clr ? 2'b00 : cause_q;
      if (req) begin
        state_q  <= HOLD;
        cnt_q    <= '0;
        arst_n_q <= '0;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          HOLD: if (cnt_q == CW'(MIN_ASSERT - 1)) begin
            arst_n_q <= arst_n_d;
            cnt_q    <= '0;
            state_q  <= (NUM_OUT == 1) ? DONE : REL;
            done_q   <= (NUM_OUT == 1);
          end else cnt_q <= cnt_q + 1'b1;
          REL: if (cnt_q == CW'(STAGE_GAP - 1)) begin
            arst_n_q <= arst_n_d;
            cnt_q    <= '0;
            if (arst_n_d[NUM_OUT-1]) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else cnt_q <= cnt_q + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule
